// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Word-organised data RAM with a valid/ready request port and a
//            one-cycle response pulse. Supports byte/halfword/word loads
//            (sign- or zero-extended) and stores with lane merging, a
//            configurable number of wait states, and fault reporting for
//            misaligned, out-of-range and illegal-size accesses.
// Ports    : clk, reset (async, active-high)
//            req_valid/req_ready handshake; req_we, req_size, req_unsigned,
//            req_addr, req_wdata request fields
//            rsp_valid (1-cycle pulse), rsp_rdata, rsp_err
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The counter is loaded with WAIT_CYCLES-1; guard the zero-wait build.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // RAM is intentionally outside the reset domain.
  logic [31:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // Access-side signals
  // --------------------------------------------------------------------------
  logic        enter_resp;
  logic        acc_we;
  logic [1:0]  acc_size;
  logic        acc_uns;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] acc_offset;
  logic [AW-1:0] acc_idx;
  logic        acc_err;
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [31:0] load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_ready = (state_q == ST_IDLE);

  // --------------------------------------------------------------------------
  // Request capture and FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The RAM access happens on the edge that enters RESP. With zero wait
  // states that edge is also the acceptance edge, so the request fields are
  // taken straight from the port instead of the (not yet loaded) registers.
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign acc_we     = (state_q == ST_IDLE) ? req_we       : we_q;
  assign acc_size   = (state_q == ST_IDLE) ? req_size     : size_q;
  assign acc_uns    = (state_q == ST_IDLE) ? req_unsigned : uns_q;
  assign acc_addr   = (state_q == ST_IDLE) ? req_addr     : addr_q;
  assign acc_wdata  = (state_q == ST_IDLE) ? req_wdata    : wdata_q;

  // Underflow of the subtraction is masked by the explicit below-base test.
  assign acc_offset = acc_addr - BASE_ADDR;
  assign acc_idx    = acc_offset[AW+1:2];

  always_comb begin
    acc_err = 1'b0;
    if (acc_size == 2'b11)                              acc_err = 1'b1;
    if (acc_size == SZ_HALF && acc_addr[0])             acc_err = 1'b1;
    if (acc_size == SZ_WORD && acc_addr[1:0] != 2'b00)  acc_err = 1'b1;
    if (acc_addr < BASE_ADDR)                           acc_err = 1'b1;
    if ((acc_offset >> (AW + 2)) != 32'd0)              acc_err = 1'b1;
  end

  assign rd_word = mem[acc_idx];

  // Store lane merge: untouched lanes keep their current contents.
  always_comb begin
    wr_word = rd_word;
    case (acc_size)
      SZ_BYTE: wr_word[{acc_addr[1:0], 3'b000} +: 8]  = acc_wdata[7:0];
      SZ_HALF: wr_word[{acc_addr[1], 4'b0000} +: 16]  = acc_wdata[15:0];
      default: wr_word = acc_wdata;
    endcase
  end

  // Load extraction and extension.
  always_comb begin
    case (acc_addr[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_size)
      SZ_BYTE: load_val = {{24{ld_byte[7] & ~acc_uns}}, ld_byte};
      SZ_HALF: load_val = {{16{ld_half[15] & ~acc_uns}}, ld_half};
      default: load_val = rd_word;
    endcase
  end

  // --------------------------------------------------------------------------
  // Response path: data/err are captured with the access, the valid pulse
  // follows one edge later (while the FSM drops back to IDLE).
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = (state_q == ST_RESP);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || acc_we) ? 32'd0 : load_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // A reset mid-transaction forces IDLE, so enter_resp can never fire for a
  // dropped store.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_err && !reset) begin
      mem[acc_idx] <= wr_word;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Purpose  : Directed self-checking bench for dmem_lsu (WAIT_CYCLES=2,
//            DEPTH=1024, BASE_ADDR=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] X = 2'b11;

  always #5 clk = ~clk;

  dmem_lsu #(
    .DEPTH       (1024),
    .WAIT_CYCLES (2),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response pulse.
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output int busy,
                      output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat  = 0;
    busy = 0;
    while (!rsp_valid && lat < 20) begin
      if (!req_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  task automatic ld(input string tag, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic exp_err);
    int lat, busy;
    logic [31:0] rd;
    logic e;
    xact(1'b0, size, uns, addr, 32'd0, lat, busy, rd, e);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, rd, exp_data);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic st(input string tag, input logic [1:0] size,
                    input logic [31:0] addr, input logic [31:0] data,
                    input logic exp_err);
    int lat, busy;
    logic [31:0] rd;
    logic e;
    xact(1'b1, size, 1'b0, addr, data, lat, busy, rd, e);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, rd, 32'd0);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy, seen;
    logic [31:0] rd;
    logic e;

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = W;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   {31'd0, rsp_err}, 32'd0);

    // Latency / busy window on a word store.
    xact(1'b1, W, 1'b0, 32'h10, 32'hDEADBEEF, lat, busy, rd, e);
    chk("sw10_lat",  32'(lat), 32'd3);
    chk("sw10_busy", 32'(busy), 32'd3);
    chk("sw10_err",  {31'd0, e}, 32'd0);
    chk("sw10_rdy",  {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("sw10_pulse", {31'd0, rsp_valid}, 32'd0);
    ld("lw10", W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

    // Sub-word stores followed by loads of every width.
    st("sw20", W, 32'h20, 32'h0000_0000, 1'b0);
    st("sb23", B, 32'h23, 32'h0000_0080, 1'b0);
    st("sh20", H, 32'h20, 32'h0000_7FFE, 1'b0);
    ld("lw20",  W, 1'b0, 32'h20, 32'h8000_7FFE, 1'b0);
    ld("lb23",  B, 1'b0, 32'h23, 32'hFFFF_FF80, 1'b0);
    ld("lbu23", B, 1'b1, 32'h23, 32'h0000_0080, 1'b0);
    ld("lh20",  H, 1'b0, 32'h20, 32'h0000_7FFE, 1'b0);
    ld("lh22",  H, 1'b0, 32'h22, 32'hFFFF_8000, 1'b0);
    ld("lhu22", H, 1'b1, 32'h22, 32'h0000_8000, 1'b0);
    ld("lb21",  B, 1'b0, 32'h21, 32'h0000_007F, 1'b0);

    // Faults.
    ld("lh21",  H, 1'b0, 32'h21, 32'h0, 1'b1);
    st("sw22",  W, 32'h22, 32'hFFFF_FFFF, 1'b1);
    ld("lw20b", W, 1'b0, 32'h20, 32'h8000_7FFE, 1'b0);
    ld("sz11",  X, 1'b0, 32'h20, 32'h0, 1'b1);
    ld("lw1000", W, 1'b0, 32'h1000, 32'h0, 1'b1);
    st("swffc", W, 32'hFFC, 32'hCAFE_F00D, 1'b0);
    ld("lwffc", W, 1'b0, 32'hFFC, 32'hCAFE_F00D, 1'b0);

    // Handshake: req_valid held high with changing addresses.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = W;
    req_addr  = 32'h10;
    @(posedge clk); #1;
    chk("hs_busy0", {31'd0, req_ready}, 32'd0);
    req_addr = 32'h1000;
    @(posedge clk); #1;
    chk("hs_v1", {31'd0, rsp_valid}, 32'd0);
    req_addr = 32'h24;
    @(posedge clk); #1;
    chk("hs_v2", {31'd0, rsp_valid}, 32'd0);
    req_addr = 32'h20;
    @(posedge clk); #1;
    chk("hs_v3",    {31'd0, rsp_valid}, 32'd1);
    chk("hs_data1", rsp_rdata, 32'hDEAD_BEEF);
    chk("hs_err1",  {31'd0, rsp_err}, 32'd0);
    chk("hs_rdy3",  {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hs_acc2", {31'd0, req_ready}, 32'd0);
    chk("hs_v4",   {31'd0, rsp_valid}, 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs_lat2",  32'(lat), 32'd3);
    chk("hs_data2", rsp_rdata, 32'h8000_7FFE);
    @(posedge clk); #1;
    chk("hs_end_v",   {31'd0, rsp_valid}, 32'd0);
    chk("hs_end_rdy", {31'd0, req_ready}, 32'd1);

    // Reset in the middle of a pending store.
    st("sw30z", W, 32'h30, 32'h0, 1'b0);
    ld("lw10b", W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = W;
    req_addr  = 32'h30;
    req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ar_rdata", rsp_rdata, 32'd0);
    chk("ar_err",   {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("ar_nopulse", 32'(seen), 32'd0);
    chk("ar_ready",   {31'd0, req_ready}, 32'd1);
    ld("lw30", W, 1'b0, 32'h30, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
